// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor
// Bit-serial unsigned subtractor, LSB first, one result bit per clock.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; diff/bout (and ovf) hold the last result
// RUN   | one bit of a - b per rising edge, W edges in total
// DONE  | one-cycle done pulse; diff/bout (and ovf) are valid
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a subtraction (accepted only in IDLE)
//   a, b       minuend / subtrahend, sampled on the accepting edge
//   busy       high in RUN and DONE
//   done       one-cycle pulse in DONE
//   diff       a - b modulo 2^W
//   bout       final borrow (a < b unsigned)
//   bit_out    difference bit of the current step
//   bit_valid  high while bit_out carries a result bit (RUN)
//   ovf        signed overflow of a - b; only present when the macro
//              SERIAL_SUB_OVF_EN is defined
module serial_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         bit_out,
    output logic         bit_valid
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          br;
    logic [CW-1:0] cnt;

    logic d;
    logic br_next;
    logic last_step;

`ifdef SERIAL_SUB_OVF_EN
    // Sign bits are lost from the shift registers as they drain, so keep
    // copies for the overflow decision on the final step.
    logic a_msb;
    logic b_msb;
`endif

    assign d         = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    assign last_step = (cnt == CW'(W - 1));

    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign done      = (state == S_DONE);
    assign bit_valid = (state == S_RUN);
    assign bit_out   = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= a[W-1];
                        b_msb <= b[W-1];
`endif
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // New bits enter at the MSB so the first (LSB) bit
                    // ends up in diff[0] after W steps.
                    diff <= {d, diff[W-1:1]};
                    if (last_step) begin
                        bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        // d is the result MSB on the last step.
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         bit_out;
    logic         bit_valid;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int tests_run = 0;
    int fails     = 0;

    serial_subtractor #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge: drives a start pulse, then follows the operation
    // until done (bounded). poke >= 0 re-drives start and new operands
    // at that step to check they are ignored mid-run.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input int poke,
                          output int cyc, output logic [7:0] bits, output int nvalid);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; nvalid = 0; bits = '0;
        while (done !== 1'b1 && cyc < 40) begin
            if (bit_valid === 1'b1) begin
                if (nvalid < W) bits[nvalid] = bit_out;
                nvalid++;
            end
            if (cyc == poke) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests_run++; if (bit_valid !== 1'b0) begin fails++; $display("FAIL reset_bit_valid got %b exp 0", bit_valid); end
        tests_run++; if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff got %h exp 00", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL reset_bout got %b exp 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
        start = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_start_ignored got busy=%b exp 0", busy); end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL release_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_basic();
        int cyc, nv; logic [7:0] bits;
        run_op(8'h05, 8'h03, -1, cyc, bits, nv);
        tests_run++; if (cyc != 8) begin fails++; $display("FAIL basic_latency got %0d exp 8", cyc); end
        tests_run++; if (nv != 8) begin fails++; $display("FAIL basic_nvalid got %0d exp 8", nv); end
        tests_run++; if (bits !== 8'h02) begin fails++; $display("FAIL basic_bits got %h exp 02", bits); end
        tests_run++; if (diff !== 8'h02) begin fails++; $display("FAIL basic_diff got %h exp 02", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL basic_bout got %b exp 0", bout); end
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_done got %b exp 1", busy); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got %b exp 0", done); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle got %b exp 0", busy); end
        @(negedge clk);
        tests_run++; if (diff !== 8'h02) begin fails++; $display("FAIL basic_hold_diff got %h exp 02", diff); end
    endtask

    task automatic test_borrow();
        int cyc, nv; logic [7:0] bits;
        run_op(8'h03, 8'h05, -1, cyc, bits, nv);
        tests_run++; if (diff !== 8'hFE) begin fails++; $display("FAIL borrow_diff got %h exp fe", diff); end
        tests_run++; if (bits !== 8'hFE) begin fails++; $display("FAIL borrow_bits got %h exp fe", bits); end
        tests_run++; if (bout !== 1'b1) begin fails++; $display("FAIL borrow_bout got %b exp 1", bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++; if (ovf !== 1'b0) begin fails++; $display("FAIL borrow_ovf got %b exp 0", ovf); end
`endif
        @(negedge clk);
        tests_run++; if (bout !== 1'b1) begin fails++; $display("FAIL borrow_hold_bout got %b exp 1", bout); end
    endtask

    task automatic test_overflow();
        int cyc, nv; logic [7:0] bits;
        run_op(8'h80, 8'h01, -1, cyc, bits, nv);
        tests_run++; if (diff !== 8'h7F) begin fails++; $display("FAIL ovf1_diff got %h exp 7f", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL ovf1_bout got %b exp 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf1_ovf got %b exp 1", ovf); end
`endif
        @(negedge clk);
        run_op(8'h00, 8'h00, -1, cyc, bits, nv);
        tests_run++; if (diff !== 8'h00) begin fails++; $display("FAIL zero_diff got %h exp 00", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL zero_bout got %b exp 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++; if (ovf !== 1'b0) begin fails++; $display("FAIL zero_ovf got %b exp 0", ovf); end
`endif
        @(negedge clk);
        run_op(8'h01, 8'h80, -1, cyc, bits, nv);
        tests_run++; if (diff !== 8'h81) begin fails++; $display("FAIL ovf2_diff got %h exp 81", diff); end
        tests_run++; if (bout !== 1'b1) begin fails++; $display("FAIL ovf2_bout got %b exp 1", bout); end
`ifdef SERIAL_SUB_OVF_EN
        tests_run++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf2_ovf got %b exp 1", ovf); end
`endif
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, nv; logic [7:0] bits; time t1, t2;
        run_op(8'h10, 8'h01, 3, cyc, bits, nv);
        t1 = $time;
        tests_run++; if (cyc != 8) begin fails++; $display("FAIL ignore_latency got %0d exp 8", cyc); end
        tests_run++; if (diff !== 8'h0F) begin fails++; $display("FAIL ignore_diff got %h exp 0f", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL ignore_bout got %b exp 0", bout); end
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy got %b exp 0", busy); end
        run_op(8'h20, 8'h21, -1, cyc, bits, nv);
        t2 = $time;
        tests_run++; if (cyc != 8) begin fails++; $display("FAIL b2b_latency got %0d exp 8", cyc); end
        tests_run++; if (diff !== 8'hFF) begin fails++; $display("FAIL b2b_diff got %h exp ff", diff); end
        tests_run++; if (bout !== 1'b1) begin fails++; $display("FAIL b2b_bout got %b exp 1", bout); end
        tests_run++; if (t2 - t1 != 100) begin fails++; $display("FAIL b2b_period got %0t exp 100", t2 - t1); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int cyc, nv, npulse; logic [7:0] bits;
        a = 8'hFF; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++; if (bit_valid !== 1'b1) begin fails++; $display("FAIL mid_running got %b exp 1", bit_valid); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
        tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL mid_rst_done got %b exp 0", done); end
        tests_run++; if (bit_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_bit_valid got %b exp 0", bit_valid); end
        tests_run++; if (diff !== 8'h00) begin fails++; $display("FAIL mid_rst_diff got %h exp 00", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL mid_rst_bout got %b exp 0", bout); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        npulse = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) npulse++;
        end
        tests_run++; if (npulse != 0) begin fails++; $display("FAIL mid_no_done got %0d pulses exp 0", npulse); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_idle_busy got %b exp 0", busy); end
        run_op(8'hFF, 8'h01, -1, cyc, bits, nv);
        tests_run++; if (cyc != 8) begin fails++; $display("FAIL post_rst_latency got %0d exp 8", cyc); end
        tests_run++; if (diff !== 8'hFE) begin fails++; $display("FAIL post_rst_diff got %h exp fe", diff); end
        tests_run++; if (bout !== 1'b0) begin fails++; $display("FAIL post_rst_bout got %b exp 0", bout); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
